handshake_producer: RTL and testbench

//  Producer end of the dav_/rfd handshake: buffers 2-bit values from a host port in a small FIFO
//  and transfers them one at a time to a consumer over numero/dav_/rfd.

---
 rtl/prod_pkg.sv | 11 +
 rtl/handshake_producer_if.sv | 28 ++
 rtl/prod_fifo.sv | 53 +++++
 rtl/handshake_producer.sv | 123 ++++++++++++
 tb/tb_handshake_producer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/prod_pkg.sv
// Shared types for the dav_/rfd handshake producer: data width and FSM state encoding.
package prod_pkg;
    localparam int DATA_W = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        WAIT_ACK = 2'd2,
        WAIT_RDY = 2'd3
    } state_t;
endpackage

// File: rtl/handshake_producer_if.sv
// Host push port plus consumer-side numero/dav_/rfd handshake, bundled for the producer.
interface handshake_producer_if
    import prod_pkg::*;
#(
    parameter int DEPTH = 4
) ();
    localparam int LW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] numero;
    logic              dav_;
    logic              rfd;
    logic [LW-1:0]     level;
    logic              busy;
    logic              err;

    modport master (
        input  in_data, in_valid, rfd,
        output in_ready, numero, dav_, level, busy, err
    );

    modport slave (
        output in_data, in_valid, rfd,
        input  in_ready, numero, dav_, level, busy, err
    );
endinterface

// File: rtl/prod_fifo.sv
// Circular DEPTH x DATA_W FIFO; head entry is always visible on rdata, no write-to-read bypass.
module prod_fifo
    import prod_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [LW-1:0]     level
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr;
    logic [AW-1:0]     r_rd;
    logic [LW-1:0]     r_level;
    logic              w_push;
    logic              w_pop;

    assign full   = (r_level == LW'(DEPTH));
    assign empty  = (r_level == '0);
    assign level  = r_level;
    assign rdata  = r_mem[r_rd];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr] <= wdata;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

// File: rtl/handshake_producer.sv
// Producer end of the dav_/rfd handshake: FIFO-buffered host values sent one per handshake.
// Optional handshake timeout with sticky err is enabled by defining PROD_TIMEOUT_EN.
module handshake_producer
    import prod_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    handshake_producer_if.master  bus
);
    localparam int LW = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_bad_cfg
        $error("handshake_producer: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 2");
    end

    state_t            r_state, w_state_n;
    logic [DATA_W-1:0] r_numero, w_numero_n;
    logic              r_dav_, w_dav_n;
    logic              w_pop;
    logic              w_tmo;
    logic [DATA_W-1:0] w_head;
    logic              w_full;
    logic              w_empty;
    logic [LW-1:0]     w_level;

    prod_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (bus.in_valid),
        .pop   (w_pop),
        .wdata (bus.in_data),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

`ifdef PROD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_waiting;

    assign w_waiting = (r_state == WAIT_ACK) || (r_state == WAIT_RDY);
    assign w_tmo     = w_waiting && (r_cnt == CNT_W'(TIMEOUT - 1));

    // Counter restarts on every state change, so each wait state gets its own budget.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_waiting && (w_state_n == r_state)) r_cnt <= r_cnt + 1'b1;
            else                                     r_cnt <= '0;
            if (w_tmo) r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign w_tmo   = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_numero <= '0;
            r_dav_   <= 1'b1;
        end else begin
            r_state  <= w_state_n;
            r_numero <= w_numero_n;
            r_dav_   <= w_dav_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_numero_n = r_numero;
        w_dav_n    = r_dav_;
        w_pop      = 1'b0;
        case (r_state)
            IDLE: begin
                w_dav_n = 1'b1;
                if (!w_empty && bus.rfd) begin
                    w_pop      = 1'b1;
                    w_numero_n = w_head;
                    w_state_n  = SETUP;
                end
            end
            // numero was loaded last cycle; dav_ falls only now so data leads strobe.
            SETUP: begin
                w_dav_n   = 1'b0;
                w_state_n = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (w_tmo) begin
                    w_dav_n   = 1'b1;
                    w_state_n = IDLE;
                end else if (!bus.rfd) begin
                    w_dav_n   = 1'b1;
                    w_state_n = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (w_tmo || bus.rfd) w_state_n = IDLE;
            end
            default: begin
                w_dav_n   = 1'b1;
                w_state_n = IDLE;
            end
        endcase
    end

    assign bus.in_ready = !w_full;
    assign bus.numero   = r_numero;
    assign bus.dav_     = r_dav_;
    assign bus.level    = w_level;
    assign bus.busy     = (r_state != IDLE);
endmodule

// File: tb/tb_handshake_producer.sv
// Directed self-checking bench for handshake_producer with a simple consumer model.
module tb_handshake_producer;
    import prod_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic clock = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   pulses = 0;
    logic prev_dav = 1'b1;

    always #5 clock = ~clock;

    handshake_producer_if #(.DEPTH(DEPTH)) hp_if ();

    handshake_producer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (hp_if)
    );

    always @(negedge clock) begin
        if (prev_dav === 1'b1 && hp_if.dav_ === 1'b0) pulses++;
        prev_dav = hp_if.dav_;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Waits for dav_ low, captures numero, acks with rfd low until dav_ rises, then re-arms rfd.
    task automatic consume(output logic [1:0] v, output bit ok);
        bit seen = 0;
        bit stable = 1;
        v  = '0;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (hp_if.dav_ === 1'b0) begin seen = 1; break; end
            tick();
        end
        if (!seen) return;
        v = hp_if.numero;
        hp_if.rfd = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (hp_if.numero !== v) stable = 0;
            if (hp_if.dav_ === 1'b1) begin seen = 1; break; end
        end
        repeat (3) begin
            tick();
            if (hp_if.numero !== v) stable = 0;
        end
        hp_if.rfd = 1'b1;
        ok = seen && stable;
    endtask

    task automatic push1(input logic [1:0] d);
        hp_if.in_data  = d;
        hp_if.in_valid = 1'b1;
        tick();
        hp_if.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        hp_if.in_valid = 1'b0;
        hp_if.in_data  = '0;
        hp_if.rfd      = 1'b0;
        tick(); tick();
        checks++; if (hp_if.dav_ !== 1'b1) begin errors++; $display("FAIL reset_dav: got %b want 1", hp_if.dav_); end
        checks++; if (hp_if.numero !== 2'd0) begin errors++; $display("FAIL reset_numero: got %0d want 0", hp_if.numero); end
        checks++; if (hp_if.level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", hp_if.level); end
        checks++; if (hp_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", hp_if.in_ready); end
        checks++; if (hp_if.busy !== 1'b0 || hp_if.err !== 1'b0) begin errors++; $display("FAIL reset_busy_err: got %b%b want 00", hp_if.busy, hp_if.err); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [1:0] v;
        bit ok;
        int p0;
        hp_if.rfd = 1'b1;
        p0 = pulses;
        push1(2'd3);
        checks++; if (hp_if.level !== 3'd1 || hp_if.numero !== 2'd0) begin errors++; $display("FAIL single_push: level=%0d numero=%0d want 1,0", hp_if.level, hp_if.numero); end
        tick();
        checks++; if (hp_if.numero !== 2'd3 || hp_if.dav_ !== 1'b1 || hp_if.busy !== 1'b1) begin errors++; $display("FAIL single_setup: numero=%0d dav_=%b busy=%b want 3,1,1", hp_if.numero, hp_if.dav_, hp_if.busy); end
        checks++; if (hp_if.level !== 3'd0) begin errors++; $display("FAIL single_pop_level: got %0d want 0", hp_if.level); end
        tick();
        checks++; if (hp_if.dav_ !== 1'b0) begin errors++; $display("FAIL single_dav_low: got %b want 0", hp_if.dav_); end
        consume(v, ok);
        checks++; if (!ok || v !== 2'd3) begin errors++; $display("FAIL single_value: got %0d ok=%0d want 3", v, ok); end
        tick(); tick();
        checks++; if (hp_if.busy !== 1'b0 || hp_if.dav_ !== 1'b1 || hp_if.level !== 3'd0) begin errors++; $display("FAIL single_idle: busy=%b dav_=%b level=%0d", hp_if.busy, hp_if.dav_, hp_if.level); end
        checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL single_pulses: got %0d want 1", pulses - p0); end
    endtask

    task automatic test_burst_full();
        logic [1:0] vals [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
        logic [1:0] v;
        bit ok;
        hp_if.rfd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push1(vals[i]);
            if (i == 2) begin
                checks++; if (hp_if.in_ready !== 1'b1) begin errors++; $display("FAIL burst_ready3: got %b want 1", hp_if.in_ready); end
            end
            if (i == 3) begin
                checks++; if (hp_if.in_ready !== 1'b0) begin errors++; $display("FAIL burst_full: got %b want 0", hp_if.in_ready); end
            end
        end
        checks++; if (hp_if.level !== 3'd4) begin errors++; $display("FAIL burst_level: got %0d want 4", hp_if.level); end
        hp_if.rfd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            consume(v, ok);
            checks++; if (!ok || v !== 2'(i)) begin errors++; $display("FAIL burst_order%0d: got %0d ok=%0d want %0d", i, v, ok, i); end
        end
        repeat (4) tick();
        checks++; if (hp_if.level !== 3'd0 || hp_if.dav_ !== 1'b1 || hp_if.busy !== 1'b0) begin errors++; $display("FAIL burst_reject5: level=%0d dav_=%b busy=%b", hp_if.level, hp_if.dav_, hp_if.busy); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd1};
        logic [1:0] v;
        bit ok;
        hp_if.rfd = 1'b0;
        push1(2'd1);
        push1(2'd2);
        checks++; if (hp_if.level !== 3'd2) begin errors++; $display("FAIL b2b_pre: got %0d want 2", hp_if.level); end
        hp_if.rfd = 1'b1;
        push1(2'd3);
        checks++; if (hp_if.level !== 3'd2 || hp_if.numero !== 2'd1) begin errors++; $display("FAIL b2b_pushpop: level=%0d numero=%0d want 2,1", hp_if.level, hp_if.numero); end
        for (int i = 0; i < 3; i++) begin
            consume(v, ok);
            checks++; if (!ok || v !== exp[i]) begin errors++; $display("FAIL b2b_order%0d: got %0d ok=%0d want %0d", i, v, ok, exp[i]); end
        end
        push1(2'd0);
        push1(2'd2);
        push1(2'd1);
        for (int i = 3; i < 6; i++) begin
            consume(v, ok);
            checks++; if (!ok || v !== exp[i]) begin errors++; $display("FAIL b2b_wrap%0d: got %0d ok=%0d want %0d", i, v, ok, exp[i]); end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        hp_if.rfd = 1'b0;
        push1(2'd1);
        push1(2'd2);
        push1(2'd3);
        hp_if.rfd = 1'b1;
        tick(); tick();
        checks++; if (hp_if.dav_ !== 1'b0 || hp_if.level !== 3'd2) begin errors++; $display("FAIL mid_wait_ack: dav_=%b level=%0d want 0,2", hp_if.dav_, hp_if.level); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (hp_if.dav_ !== 1'b1 || hp_if.level !== 3'd0 || hp_if.busy !== 1'b0 || hp_if.numero !== 2'd0) begin errors++; $display("FAIL mid_reset: dav_=%b level=%0d busy=%b numero=%0d", hp_if.dav_, hp_if.level, hp_if.busy, hp_if.numero); end
        tick(); tick();
        checks++; if (hp_if.dav_ !== 1'b1 || hp_if.busy !== 1'b0) begin errors++; $display("FAIL mid_discard: dav_=%b busy=%b want 1,0", hp_if.dav_, hp_if.busy); end
    endtask

    task automatic test_timeout();
        logic [1:0] v;
        bit ok;
        bit hold = 1;
        hp_if.rfd = 1'b1;
        push1(2'd2);
        for (int i = 0; i < 10; i++) begin
            if (hp_if.dav_ === 1'b0) break;
            tick();
        end
        checks++; if (hp_if.dav_ !== 1'b0) begin errors++; $display("FAIL tmo_dav_low: got %b want 0", hp_if.dav_); end
`ifdef PROD_TIMEOUT_EN
        repeat (TIMEOUT - 1) begin
            tick();
            if (hp_if.dav_ !== 1'b0 || hp_if.err !== 1'b0) hold = 0;
        end
        checks++; if (!hold) begin errors++; $display("FAIL tmo_hold: dav_ rose or err set early, want %0d low cycles", TIMEOUT); end
        tick();
        checks++; if (hp_if.dav_ !== 1'b1 || hp_if.err !== 1'b1 || hp_if.busy !== 1'b0) begin errors++; $display("FAIL tmo_abort: dav_=%b err=%b busy=%b want 1,1,0", hp_if.dav_, hp_if.err, hp_if.busy); end
        push1(2'd1);
        consume(v, ok);
        checks++; if (!ok || v !== 2'd1) begin errors++; $display("FAIL tmo_next: got %0d ok=%0d want 1", v, ok); end
        checks++; if (hp_if.err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b want 1", hp_if.err); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (hp_if.err !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b want 0", hp_if.err); end
`else
        repeat (20) begin
            tick();
            if (hp_if.dav_ !== 1'b0 || hp_if.err !== 1'b0) hold = 0;
        end
        checks++; if (!hold) begin errors++; $display("FAIL notmo_hold: dav_=%b err=%b want 0,0", hp_if.dav_, hp_if.err); end
        consume(v, ok);
        checks++; if (!ok || v !== 2'd2) begin errors++; $display("FAIL notmo_value: got %0d ok=%0d want 2", v, ok); end
        checks++; if (hp_if.err !== 1'b0) begin errors++; $display("FAIL notmo_err: got %b want 0", hp_if.err); end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst_full();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
